// File: rtl/altera_emif_arch_nf_amm_arb.sv
// Round-robin arbiter that shares one EMIF Avalon-MM port among NUM_REQ masters.
// Write bursts keep the grant until the last beat. Read commands are logged in an
// ID FIFO so each returning read beat is steered to the requester that issued it.

// Per-requester qualification: eligibility and burstcount sanitising.
module altera_emif_arch_nf_amm_arb_lane #(
  parameter int BCNT_W = 7
) (
  input  logic              rd,
  input  logic              wr,
  input  logic              rdq_full,
  input  logic [BCNT_W-1:0] bcnt_in,
  output logic              elig,
  output logic [BCNT_W-1:0] bcnt_eff
);
  // A read can only compete while there is room to log it; writes always compete.
  assign elig     = (rd & ~rdq_full) | wr;
  // A zero burstcount is illegal on AMM; treat it as a single beat.
  assign bcnt_eff = (bcnt_in == '0) ? BCNT_W'(1) : bcnt_in;
endmodule

module altera_emif_arch_nf_amm_arb #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 512,
  parameter int BCNT_W    = 7,
  parameter int RDQ_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ*BCNT_W-1:0]   req_burstcount,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_byteenable,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_readdatavalid,
  output logic                        amm_read,
  output logic                        amm_write,
  output logic [ADDR_W-1:0]           amm_address,
  output logic [BCNT_W-1:0]           amm_burstcount,
  output logic [DATA_W-1:0]           amm_writedata,
  output logic [DATA_W/8-1:0]         amm_byteenable,
  input  logic                        amm_waitrequest,
  input  logic [DATA_W-1:0]           amm_readdata,
  input  logic                        amm_readdatavalid,
  output logic                        rsp_err
);
  localparam int BE_W = DATA_W/8;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int QA_W = $clog2(RDQ_DEPTH);
  localparam int QC_W = QA_W + 1;

  typedef enum logic {S_IDLE, S_WBURST} state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [BCNT_W-1:0] len;
  } rdq_ent_t;

  state_t                          state;
  logic [ID_W-1:0]                 rr_ptr, lock, sel;
  logic                            sel_vld;
  logic [BCNT_W-1:0]               beats_left, hold_bcnt;
  logic [ADDR_W-1:0]               hold_addr;
  logic                            accept, push, pop, rsp_vld;

  logic [NUM_REQ-1:0]              elig;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr;
  logic [NUM_REQ-1:0][BCNT_W-1:0]  bcnt;
  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata;
  logic [NUM_REQ-1:0][BE_W-1:0]    be;

  rdq_ent_t                        rdq_mem [RDQ_DEPTH];
  rdq_ent_t                        rdq_head;
  logic [QA_W-1:0]                 rdq_wp, rdq_rp;
  logic [QC_W-1:0]                 rdq_cnt;
  logic                            rdq_full, rdq_empty;
  logic [BCNT_W-1:0]               rd_beat;

  // Unpack the flattened requester buses and qualify each requester.
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      assign addr[g]  = req_address[g*ADDR_W +: ADDR_W];
      assign wdata[g] = req_writedata[g*DATA_W +: DATA_W];
      assign be[g]    = req_byteenable[g*BE_W +: BE_W];
      altera_emif_arch_nf_amm_arb_lane #(.BCNT_W(BCNT_W)) u_lane (
        .rd       (req_read[g]),
        .wr       (req_write[g]),
        .rdq_full (rdq_full),
        .bcnt_in  (req_burstcount[g*BCNT_W +: BCNT_W]),
        .elig     (elig[g]),
        .bcnt_eff (bcnt[g])
      );
    end
  endgenerate

  // Full is judged on the registered count, so a pop frees space only next cycle.
  assign rdq_full  = (rdq_cnt == QC_W'(RDQ_DEPTH));
  assign rdq_empty = (rdq_cnt == '0);
  assign rdq_head  = rdq_mem[rdq_rp];

  // Round-robin pick: walk down so the last hit is the nearest one at/after rr_ptr.
  always_comb begin
    int idx;
    sel     = rr_ptr;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (elig[idx]) begin
        sel     = ID_W'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  // Zero-latency command mux; only the granted requester sees the EMIF stall.
  always_comb begin
    amm_read        = 1'b0;
    amm_write       = 1'b0;
    amm_address     = addr[sel];
    amm_burstcount  = bcnt[sel];
    amm_writedata   = wdata[sel];
    amm_byteenable  = be[sel];
    req_waitrequest = '1;
    if (!reset_n) begin
      amm_read  = 1'b0;
      amm_write = 1'b0;
    end else if (state == S_WBURST) begin
      // Burst continuation: address/burstcount frozen from the first beat, and a
      // read raised by the lock owner is held off until the burst completes.
      amm_write      = req_write[lock];
      amm_address    = hold_addr;
      amm_burstcount = hold_bcnt;
      amm_writedata  = wdata[lock];
      amm_byteenable = be[lock];
      if (req_write[lock]) req_waitrequest[lock] = amm_waitrequest;
    end else if (sel_vld) begin
      // A requester raising both commands is served as a write.
      amm_write = req_write[sel];
      amm_read  = ~req_write[sel];
      req_waitrequest[sel] = amm_waitrequest;
    end
  end

  assign accept = (amm_read | amm_write) & ~amm_waitrequest;
  assign push   = accept & amm_read;

  // Grant FSM: round-robin pointer update and write-burst lock tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      lock       <= '0;
      beats_left <= '0;
      hold_addr  <= '0;
      hold_bcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rr_ptr <= (sel == ID_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
            if (amm_write && amm_burstcount > BCNT_W'(1)) begin
              state      <= S_WBURST;
              lock       <= sel;
              beats_left <= amm_burstcount - BCNT_W'(1);
              hold_addr  <= amm_address;
              hold_bcnt  <= amm_burstcount;
            end
          end
        end
        S_WBURST: begin
          if (accept) begin
            beats_left <= beats_left - BCNT_W'(1);
            if (beats_left == BCNT_W'(1)) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read response steering from the ID FIFO head.
  assign rsp_vld      = reset_n & amm_readdatavalid & ~rdq_empty;
  assign pop          = rsp_vld & (rd_beat == rdq_head.len - BCNT_W'(1));
  assign req_readdata = amm_readdata;

  always_comb begin
    req_readdatavalid = '0;
    if (rsp_vld) req_readdatavalid[rdq_head.id] = 1'b1;
  end

  // ID FIFO storage; contents need no reset since the count guards them.
  always_ff @(posedge clk) begin
    if (push) rdq_mem[rdq_wp] <= '{id: sel, len: amm_burstcount};
  end

  // ID FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdq_wp  <= '0;
      rdq_rp  <= '0;
      rdq_cnt <= '0;
    end else begin
      if (push) rdq_wp <= rdq_wp + 1'b1;
      if (pop)  rdq_rp <= rdq_rp + 1'b1;
      rdq_cnt <= rdq_cnt + QC_W'(push) - QC_W'(pop);
    end
  end

  // Beat counter within the burst at the FIFO head.
  always_ff @(posedge clk) begin
    if (!reset_n)     rd_beat <= '0;
    else if (pop)     rd_beat <= '0;
    else if (rsp_vld) rd_beat <= rd_beat + 1'b1;
  end

  // Sticky flag for read data arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!reset_n)                            rsp_err <= 1'b0;
    else if (amm_readdatavalid && rdq_empty) rsp_err <= 1'b1;
  end
endmodule

// File: tb/tb_altera_emif_arch_nf_amm_arb.sv
// Bench for the AMM round-robin arbiter: reset, fairness, random arbitration,
// write-burst locking, burstcount 0, read routing, FIFO full, spurious response.
module tb_altera_emif_arch_nf_amm_arb;
  localparam int NR = 4, AW = 16, DW = 32, BW = 4, QD = 4, BEW = DW/8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_read, req_write;
  logic [NR*AW-1:0]  req_address;
  logic [NR*BW-1:0]  req_burstcount;
  logic [NR*DW-1:0]  req_writedata;
  logic [NR*BEW-1:0] req_byteenable;
  logic [NR-1:0]     req_waitrequest, req_readdatavalid;
  logic [DW-1:0]     req_readdata;
  logic              amm_read, amm_write;
  logic [AW-1:0]     amm_address;
  logic [BW-1:0]     amm_burstcount;
  logic [DW-1:0]     amm_writedata;
  logic [BEW-1:0]    amm_byteenable;
  logic              amm_waitrequest;
  logic [DW-1:0]     amm_readdata;
  logic              amm_readdatavalid;
  logic              rsp_err;

  int vectors = 0;
  int errors  = 0;

  altera_emif_arch_nf_amm_arb #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BCNT_W(BW), .RDQ_DEPTH(QD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_read(req_read), .req_write(req_write), .req_address(req_address),
    .req_burstcount(req_burstcount), .req_writedata(req_writedata),
    .req_byteenable(req_byteenable), .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
    .amm_read(amm_read), .amm_write(amm_write), .amm_address(amm_address),
    .amm_burstcount(amm_burstcount), .amm_writedata(amm_writedata),
    .amm_byteenable(amm_byteenable), .amm_waitrequest(amm_waitrequest),
    .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [BW-1:0] bc);
    req_read[i]  = rd;
    req_write[i] = wr;
    req_address[i*AW +: AW]     = a;
    req_burstcount[i*BW +: BW]  = bc;
    req_writedata[i*DW +: DW]   = $urandom;
    req_byteenable[i*BEW +: BEW] = '1;
  endtask

  task automatic clear_inputs();
    req_read = '0; req_write = '0; req_address = '0; req_burstcount = '0;
    req_writedata = '0; req_byteenable = '0;
    amm_waitrequest = 1'b0; amm_readdata = '0; amm_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(i), BW'(1));
    amm_waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      vectors++;
      if (amm_read !== 1'b0 || amm_write !== 1'b0) begin
        errors++; $display("FAIL reset_cmd cyc%0d got rd=%b wr=%b want 0 0", c, amm_read, amm_write);
      end
      vectors++;
      if (req_waitrequest !== '1) begin
        errors++; $display("FAIL reset_waitreq cyc%0d got %b want 1111", c, req_waitrequest);
      end
      vectors++;
      if (rsp_err !== 1'b0 || req_readdatavalid !== '0) begin
        errors++; $display("FAIL reset_rsp cyc%0d got err=%b rdv=%b want 0 0000", c, rsp_err, req_readdatavalid);
      end
    end
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    int ptr, exp;
    int cnt[NR];
    int rq[$];
    do_reset();
    ptr = 0;
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'($urandom), BW'(1));
      amm_readdatavalid = (rq.size() > 0);
      amm_readdata = $urandom;
      #1;
      exp = ptr;
      vectors++;
      if (amm_read !== 1'b1 || req_waitrequest !== ~onehot(exp) ||
          amm_address !== req_address[exp*AW +: AW]) begin
        errors++; $display("FAIL rr_grant cyc%0d got rd=%b wreq=%b addr=%h want rd=1 grant=%0d",
                           c, amm_read, req_waitrequest, amm_address, exp);
      end
      if (rq.size() > 0) begin
        vectors++;
        if (req_readdatavalid !== onehot(rq[0]) || req_readdata !== amm_readdata) begin
          errors++; $display("FAIL rr_rdv cyc%0d got %b want %b", c, req_readdatavalid, onehot(rq[0]));
        end
        void'(rq.pop_front());
      end
      rq.push_back(exp);
      cnt[exp]++;
      ptr = (exp + 1) % NR;
    end
    @(negedge clk);
    req_read = '0;
    amm_readdatavalid = 1'b1;
    #1;
    vectors++;
    if (req_readdatavalid !== onehot(rq[0])) begin
      errors++; $display("FAIL rr_drain got %b want %b", req_readdatavalid, onehot(rq[0]));
    end
    for (int i = 0; i < NR; i++) begin
      vectors++;
      if (cnt[i] != 25) begin
        errors++; $display("FAIL rr_share req%0d got %0d want 25", i, cnt[i]);
      end
    end
    @(negedge clk);
    amm_readdatavalid = 1'b0;
  endtask

  task automatic test_rr_random();
    int ptr, sel;
    logic [NR-1:0] mask, exp_wr;
    logic wreq;
    int rq[$];
    do_reset();
    ptr = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      mask = NR'($urandom_range(0, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) set_req(i, mask[i], 1'b0, AW'($urandom), BW'(1));
      wreq = 1'($urandom_range(0, 1));
      amm_waitrequest = wreq;
      amm_readdatavalid = (rq.size() > 0);
      amm_readdata = $urandom;
      #1;
      sel = -1;
      for (int k = 0; k < NR && sel < 0; k++)
        if (mask[(ptr + k) % NR]) sel = (ptr + k) % NR;
      exp_wr = '1;
      if (sel >= 0) exp_wr[sel] = wreq;
      vectors++;
      if (amm_read !== (sel >= 0) || req_waitrequest !== exp_wr) begin
        errors++; $display("FAIL rand_grant cyc%0d mask=%b got rd=%b wreq=%b want rd=%b wreq=%b",
                           c, mask, amm_read, req_waitrequest, (sel >= 0), exp_wr);
      end
      vectors++;
      if (req_readdatavalid !== ((rq.size() > 0) ? onehot(rq[0]) : '0)) begin
        errors++; $display("FAIL rand_rdv cyc%0d got %b", c, req_readdatavalid);
      end
      if (rq.size() > 0) void'(rq.pop_front());
      if (sel >= 0 && !wreq) begin
        rq.push_back(sel);
        ptr = (sel + 1) % NR;
      end
    end
    @(negedge clk);
    req_read = '0;
    amm_readdatavalid = (rq.size() > 0);
    @(negedge clk);
    amm_readdatavalid = 1'b0;
  endtask

  task automatic test_write_burst();
    logic [AW-1:0] a, b;
    logic wreq;
    int beats;
    do_reset();
    a = AW'($urandom); b = AW'($urandom);
    @(negedge clk);
    set_req(0, 1'b0, 1'b1, a, BW'(4));
    set_req(1, 1'b0, 1'b1, b, BW'(1));
    beats = 0;
    for (int c = 0; c < 60 && beats < 4; c++) begin
      if (c > 0) @(negedge clk);
      wreq = 1'($urandom_range(0, 1));
      amm_waitrequest = wreq;
      req_writedata[0 +: DW] = $urandom;
      if (beats > 0) begin
        req_address[0 +: AW] = AW'($urandom);
        req_burstcount[0 +: BW] = BW'($urandom);
      end
      #1;
      vectors++;
      if (amm_write !== 1'b1 || amm_read !== 1'b0 || amm_address !== a ||
          amm_burstcount !== BW'(4) || amm_writedata !== req_writedata[0 +: DW] ||
          req_waitrequest !== {3'b111, wreq}) begin
        errors++; $display("FAIL wburst_beat%0d got wr=%b addr=%h bc=%0d wreq=%b want addr=%h bc=4 wreq=%b",
                           beats, amm_write, amm_address, amm_burstcount, req_waitrequest, a, {3'b111, wreq});
      end
      if (!wreq) beats++;
    end
    vectors++;
    if (beats != 4) begin
      errors++; $display("FAIL wburst_timeout got %0d beats want 4", beats);
    end
    @(negedge clk);
    req_write[0] = 1'b0;
    amm_waitrequest = 1'b0;
    #1;
    vectors++;
    if (amm_write !== 1'b1 || amm_address !== b || amm_burstcount !== BW'(1) ||
        req_waitrequest !== 4'b1101) begin
      errors++; $display("FAIL wburst_next got addr=%h wreq=%b want addr=%h wreq=1101",
                         amm_address, req_waitrequest, b);
    end
    @(negedge clk);
    req_write = '0;
  endtask

  task automatic test_bc_zero();
    logic [AW-1:0] a;
    do_reset();
    a = AW'($urandom);
    @(negedge clk);
    set_req(0, 1'b0, 1'b1, a, BW'(0));
    set_req(1, 1'b0, 1'b1, AW'($urandom), BW'(2));
    #1;
    vectors++;
    if (amm_burstcount !== BW'(1) || req_waitrequest !== 4'b1110 || amm_address !== a) begin
      errors++; $display("FAIL bc0_first got bc=%0d wreq=%b want bc=1 wreq=1110", amm_burstcount, req_waitrequest);
    end
    @(negedge clk); #1;
    vectors++;
    if (amm_burstcount !== BW'(2) || req_waitrequest !== 4'b1101) begin
      errors++; $display("FAIL bc0_release got bc=%0d wreq=%b want bc=2 wreq=1101", amm_burstcount, req_waitrequest);
    end
    @(negedge clk);
    req_write = '0;
    @(negedge clk);
  endtask

  task automatic test_read_routing();
    int exp_ids[$];
    int got;
    logic rdv;
    do_reset();
    // two reads of length 2 and 3 expand to one expected owner per beat
    exp_ids = '{0, 0, 1, 1, 1};
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, AW'($urandom), BW'(2));
    set_req(1, 1'b1, 1'b0, AW'($urandom), BW'(3));
    #1;
    vectors++;
    if (amm_read !== 1'b1 || amm_burstcount !== BW'(2) || req_waitrequest !== 4'b1110) begin
      errors++; $display("FAIL route_cmd0 got bc=%0d wreq=%b want bc=2 wreq=1110", amm_burstcount, req_waitrequest);
    end
    @(negedge clk);
    req_read[0] = 1'b0;
    #1;
    vectors++;
    if (amm_read !== 1'b1 || amm_burstcount !== BW'(3) || req_waitrequest !== 4'b1101) begin
      errors++; $display("FAIL route_cmd1 got bc=%0d wreq=%b want bc=3 wreq=1101", amm_burstcount, req_waitrequest);
    end
    @(negedge clk);
    req_read = '0;
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      @(negedge clk);
      rdv = 1'($urandom_range(0, 1));
      amm_readdatavalid = rdv;
      amm_readdata = $urandom;
      #1;
      vectors++;
      if (req_readdatavalid !== (rdv ? onehot(exp_ids[got]) : '0) || req_readdata !== amm_readdata) begin
        errors++; $display("FAIL route_beat%0d got %b want %b", got, req_readdatavalid,
                           rdv ? onehot(exp_ids[got]) : '0);
      end
      if (rdv) got++;
    end
    vectors++;
    if (got != 5) begin
      errors++; $display("FAIL route_timeout got %0d beats want 5", got);
    end
    @(negedge clk);
    amm_readdatavalid = 1'b1;
    #1;
    vectors++;
    if (req_readdatavalid !== '0) begin
      errors++; $display("FAIL route_extra got %b want 0000", req_readdatavalid);
    end
    @(negedge clk);
    amm_readdatavalid = 1'b0;
    #1;
    vectors++;
    if (rsp_err !== 1'b1) begin
      errors++; $display("FAIL route_empty got err=%b want 1", rsp_err);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, AW'($urandom), BW'(1));
    for (int c = 0; c < QD; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      vectors++;
      if (amm_read !== 1'b1 || req_waitrequest !== 4'b1110) begin
        errors++; $display("FAIL full_fill%0d got rd=%b wreq=%b want 1 1110", c, amm_read, req_waitrequest);
      end
    end
    @(negedge clk);
    set_req(2, 1'b0, 1'b1, AW'($urandom), BW'(1));
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      vectors++;
      if (amm_read !== 1'b0 || amm_write !== 1'b1 || req_waitrequest !== 4'b1011) begin
        errors++; $display("FAIL full_write%0d got rd=%b wr=%b wreq=%b want 0 1 1011",
                           c, amm_read, amm_write, req_waitrequest);
      end
    end
    @(negedge clk);
    req_write[2] = 1'b0;
    amm_readdatavalid = 1'b1;
    #1;
    vectors++;
    if (req_readdatavalid !== 4'b0001 || amm_read !== 1'b0 || req_waitrequest !== 4'b1111) begin
      errors++; $display("FAIL full_pop got rdv=%b rd=%b wreq=%b want 0001 0 1111",
                         req_readdatavalid, amm_read, req_waitrequest);
    end
    @(negedge clk);
    amm_readdatavalid = 1'b0;
    #1;
    vectors++;
    if (amm_read !== 1'b1 || req_waitrequest !== 4'b1110) begin
      errors++; $display("FAIL full_unblock got rd=%b wreq=%b want 1 1110", amm_read, req_waitrequest);
    end
    @(negedge clk); #1;
    vectors++;
    if (amm_read !== 1'b0 || req_waitrequest !== 4'b1111) begin
      errors++; $display("FAIL full_again got rd=%b wreq=%b want 0 1111", amm_read, req_waitrequest);
    end
    @(negedge clk);
    req_read = '0;
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    amm_readdatavalid = 1'b1;
    #1;
    vectors++;
    if (req_readdatavalid !== '0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL spur_same got rdv=%b err=%b want 0000 0", req_readdatavalid, rsp_err);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      amm_readdatavalid = 1'b0;
      #1;
      vectors++;
      if (rsp_err !== 1'b1) begin
        errors++; $display("FAIL spur_sticky%0d got err=%b want 1", c, rsp_err);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (rsp_err !== 1'b0) begin
      errors++; $display("FAIL spur_clear got err=%b want 0", rsp_err);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_rr_fairness();
    test_rr_random();
    test_write_burst();
    test_bc_zero();
    test_read_routing();
    test_fifo_full();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
